// File: rtl/gemm_result_writer.sv
// gemm_result_writer: buffers GeMM C-block results in a FIFO and writes them to C SRAM at base + M*N_size + N.
// Optional GEMM_WRITER_BYPASS_EN: cut-through straight to the SRAM port when the FIFO is empty and ready.
module gemm_result_writer #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 512,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] C_base_addr_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic                 result_valid_i,
    input  logic [AddrWidth-1:0] M_count_write_i,
    input  logic [AddrWidth-1:0] N_count_write_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic                 sram_req_o,
    input  logic                 sram_ready_i,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);
    localparam int PtrW = $clog2(FifoDepth);

    typedef enum logic [1:0] {WriterIdle, WriterRun, WriterDone} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] base_q, stride_q, total_q, written_q;
    logic                 overflow_q;
    logic [AddrWidth-1:0] addr_mem [FifoDepth];
    logic [DataWidth-1:0] data_mem [FifoDepth];
    logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
    logic                 empty, full, run, launch, push, pop, hs, drop, bypass;
    logic [AddrWidth-1:0] push_addr, total_d;

    assign run       = state_q == WriterRun;
    assign launch    = state_q == WriterIdle && start_i;
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {PtrW{1'b0}}};
    assign push_addr = base_q + M_count_write_i * stride_q + N_count_write_i;
    assign total_d   = M_size_i * N_size_i;

`ifdef GEMM_WRITER_BYPASS_EN
    assign bypass       = empty && run && result_valid_i && sram_ready_i;
    assign sram_addr_o  = bypass ? push_addr : empty ? '0 : addr_mem[rd_ptr_q[PtrW-1:0]];
    assign sram_wdata_o = bypass ? result_data_i : empty ? '0 : data_mem[rd_ptr_q[PtrW-1:0]];
`else
    assign bypass       = 1'b0;
    assign sram_addr_o  = empty ? '0 : addr_mem[rd_ptr_q[PtrW-1:0]];
    assign sram_wdata_o = empty ? '0 : data_mem[rd_ptr_q[PtrW-1:0]];
`endif

    assign sram_req_o = !empty || bypass;
    assign hs         = sram_req_o && sram_ready_i;
    assign pop        = !empty && sram_ready_i;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push       = run && result_valid_i && !bypass && (!full || pop);
    assign drop       = run && result_valid_i && full && !pop;
    assign busy_o     = state_q != WriterIdle;
    assign done_o     = state_q == WriterDone;
    assign overflow_o = overflow_q;

    always_comb begin
        state_d = state_q;
        if (launch)
            state_d = (total_d == '0) ? WriterDone : WriterRun;
        else if (run && hs && written_q + AddrWidth'(1) == total_q)
            state_d = WriterDone;
        else if (state_q == WriterDone)
            state_d = WriterIdle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WriterIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            total_q    <= '0;
            written_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            if (launch) begin
                base_q     <= C_base_addr_i;
                stride_q   <= N_size_i;
                total_q    <= total_d;
                written_q  <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (hs) written_q <= written_q + AddrWidth'(1);
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q[PtrW-1:0]] <= push_addr;
            data_mem[wr_ptr_q[PtrW-1:0]] <= result_data_i;
        end
    end
endmodule

// File: tb/tb_gemm_result_writer.sv
// tb_gemm_result_writer: directed jobs with a scoreboard of expected SRAM writes checked by a monitor.
module tb_gemm_result_writer;
    localparam int AW = 16;
    localparam int DW = 512;
`ifdef GEMM_WRITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, ready = 1'b0;
    logic [AW-1:0] base = '0, msz = '0, nsz = '0, mc = '0, nc = '0;
    logic [DW-1:0] rdata = '0;
    logic          req, busy, done, ovf;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            tests = 0, fails = 0, cyc = 0, hs_cyc = -10, st_cyc = 0, done_cnt = 0, d0;
    bit            zero_job = 1'b0;
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    logic [AW-1:0] wrap_tbl [6] = '{16'hFFFE, 16'h0001, 16'hFFFF, 16'h0002, 16'h0000, 16'h0003};

    gemm_result_writer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .C_base_addr_i(base),
        .M_size_i(msz), .N_size_i(nsz), .result_valid_i(valid),
        .M_count_write_i(mc), .N_count_write_i(nc), .result_data_i(rdata),
        .sram_req_o(req), .sram_ready_i(ready), .sram_addr_o(addr), .sram_wdata_o(wdata),
        .busy_o(busy), .done_o(done), .overflow_o(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkd(input int k);
        return {16{32'hC0DE0000 ^ (32'(k) * 32'h01010101)}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] m, input logic [AW-1:0] n, input logic [AW-1:0] ea,
                        input int k, input bit keep);
        valid = 1'b1; mc = m; nc = n; rdata = mkd(k);
        if (keep) begin qa.push_back(ea); qd.push_back(mkd(k)); end
        tick;
        valid = 1'b0;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] m, input logic [AW-1:0] n);
        base = b; msz = m; nsz = n; st_cyc = cyc; start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_job(input int dc);
        for (int i = 0; i < 60 && done_cnt == dc; i++) tick;
        repeat (3) tick;
        chk("done_once", done_cnt - dc, 1);
        chk("sb_empty", qa.size(), 0);
        chk("idle_not_busy", busy, 0);
    endtask

    task automatic chk_reset_vals;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (req && ready) begin
                hs_cyc = cyc;
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr %0h issued with empty scoreboard", addr);
                end else begin
                    chk("wr_addr", addr, qa.pop_front());
                    chk("wr_data", wdata, qd.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", cyc, zero_job ? st_cyc + 1 : hs_cyc + 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick;
        chk_reset_vals;
        rst = 1'b0;
        tick;

        // Base case with latency check on the first block
        ready = 1'b1; d0 = done_cnt;
        start_job(16'h100, 2, 3);
        valid = 1'b1; mc = 0; nc = 0; rdata = mkd(0);
        qa.push_back(16'h100); qd.push_back(mkd(0));
        #1 chk("lat_same_cycle", req, BYP);
        tick;
        valid = 1'b0;
        chk("lat_next_cycle", req, !BYP);
        for (int k = 1; k < 6; k++) send(AW'(k / 3), AW'(k % 3), AW'(16'h100 + k), k, 1'b1);
        finish_job(d0);

        // Backpressure with stable head
        ready = 1'b0; d0 = done_cnt;
        start_job(16'h200, 2, 2);
        for (int k = 0; k < 3; k++) send(AW'(k / 2), AW'(k % 2), AW'(16'h200 + k), 10 + k, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("bp_addr_stable", addr, 16'h200);
        end
        chk("bp_req", req, 1);
        chk("bp_data", wdata, mkd(10));
        chk("bp_ovf", ovf, 0);
        ready = 1'b1;
        send(1, 1, 16'h203, 13, 1'b1);
        finish_job(d0);

        // Overflow: fifth result dropped, job of four completes, flag stays sticky
        ready = 1'b0; d0 = done_cnt;
        start_job(16'h300, 1, 4);
        for (int k = 0; k < 5; k++) send(0, AW'(k), AW'(16'h300 + k), 20 + k, k < 4);
        chk("ovf_set", ovf, 1);
        chk("ovf_busy", busy, 1);
        ready = 1'b1;
        finish_job(d0);
        chk("ovf_sticky", ovf, 1);

        // Zero-size job clears overflow and finishes next cycle
        zero_job = 1'b1; d0 = done_cnt;
        start_job(16'h600, 0, 5);
        chk("zero_done", done, 1);
        chk("zero_ovf_cleared", ovf, 0);
        chk("zero_no_req", req, 0);
        finish_job(d0);
        zero_job = 1'b0;

        // Address wrap, column-major order
        d0 = done_cnt;
        start_job(16'hFFFE, 2, 3);
        for (int n = 0; n < 3; n++)
            for (int m = 0; m < 2; m++) send(AW'(m), AW'(n), wrap_tbl[n * 2 + m], 30 + n * 2 + m, 1'b1);
        finish_job(d0);

        // Full FIFO with simultaneous push and pop
        ready = 1'b0; d0 = done_cnt;
        start_job(16'h400, 1, 5);
        for (int k = 0; k < 4; k++) send(0, AW'(k), AW'(16'h400 + k), 40 + k, 1'b1);
        ready = 1'b1;
        send(0, 4, 16'h404, 44, 1'b1);
        chk("fullpp_ovf", ovf, 0);
        finish_job(d0);

        // Reset mid-job with an entry still buffered
        ready = 1'b1;
        start_job(16'h500, 2, 3);
        send(0, 0, 16'h500, 50, 1'b1);
        send(0, 1, 16'h501, 51, 1'b1);
        tick;
        chk("mid_sb_drained", qa.size(), 0);
        ready = 1'b0;
        send(0, 2, 16'h502, 52, 1'b0);
        rst = 1'b1;
        tick;
        chk_reset_vals;
        rst = 1'b0; ready = 1'b1;
        tick;
        chk("no_req_after_reset", req, 0);
        d0 = done_cnt;
        start_job(16'h700, 1, 2);
        send(0, 0, 16'h700, 60, 1'b1);
        send(0, 1, 16'h701, 61, 1'b1);
        finish_job(d0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
